pc_fetch_stage: RTL and testbench

//  Fetch stage directly downstream of the 4:1 PC-select mux. Holds the PC register,

---
 rtl/cpu_pkg.sv | 15 +
 rtl/pc_fetch_stage_if.sv | 33 +++
 rtl/pc_fetch_stage.sv | 106 ++++++++++
 tb/tb_pc_fetch_stage.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, bubble instruction and the fetch FSM
// state encoding.
package cpu_pkg;

  localparam int unsigned PC_W    = 8;
  localparam logic [7:0]  NOP_INS = 8'h00;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    INT_SAVE = 2'd2,
    INT_JUMP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_stage_if.sv
// Fetch-stage bus: PC-mux feedback, instruction memory, hazard controls,
// IF/ID register and interrupt return-address signals.
interface pc_fetch_stage_if #(
    parameter int unsigned PC_W = cpu_pkg::PC_W
);
    logic [PC_W-1:0] next_pc;
    logic [PC_W-1:0] imem_data;
    logic            stall;
    logic            flush;
    logic            irq;
    logic [PC_W-1:0] imem_addr;
    logic [PC_W-1:0] pc_plus1;
    logic            force_vec;
    logic [PC_W-1:0] if_id_instr;
    logic [PC_W-1:0] if_id_pc1;
    logic            if_id_valid;
    logic [PC_W-1:0] ret_addr;
    logic            ret_we;
    logic            int_ack;

    // master is the fetch stage itself
    modport master (
        input  next_pc, imem_data, stall, flush, irq,
        output imem_addr, pc_plus1, force_vec, if_id_instr, if_id_pc1,
               if_id_valid, ret_addr, ret_we, int_ack
    );

    modport slave (
        output next_pc, imem_data, stall, flush, irq,
        input  imem_addr, pc_plus1, force_vec, if_id_instr, if_id_pc1,
               if_id_valid, ret_addr, ret_we, int_ack
    );
endinterface

// File: rtl/pc_fetch_stage.sv
// Fetch stage: PC register, IF/ID pipeline register and a four-state FSM that
// sequences boot and interrupt entry by forcing the PC mux onto the vector.
module pc_fetch_stage #(
    parameter int unsigned     PC_W    = cpu_pkg::PC_W,
    parameter logic [PC_W-1:0] NOP_INS = cpu_pkg::NOP_INS
) (
    input  logic              clk,
    input  logic              rst,
    pc_fetch_stage_if.master  bus
);
    import cpu_pkg::*;

    fetch_state_t    state, state_nxt;
    logic [PC_W-1:0] pc;
    logic            pending;
    logic            go_int;

    assign bus.imem_addr = pc;
    assign bus.pc_plus1  = pc + PC_W'(1);

    // Interrupt entry only when RUN is otherwise idle; stall/flush defer it.
    assign go_int = (state == RUN) && !bus.flush && !bus.stall && pending;

    always_ff @(posedge clk) begin
        if (rst) state <= BOOT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            BOOT:     state_nxt = RUN;
            RUN:      if (go_int) state_nxt = INT_SAVE;
            INT_SAVE: state_nxt = INT_JUMP;
            INT_JUMP: state_nxt = RUN;
            default:  state_nxt = BOOT;
        endcase
    end

    always_comb begin
        bus.force_vec = (state == BOOT) || (state == INT_JUMP);
    end

    // Clear on INT_SAVE entry wins over a coincident irq.
    always_ff @(posedge clk) begin
        if (rst)         pending <= 1'b0;
        else if (go_int) pending <= 1'b0;
        else if (bus.irq) pending <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc              <= '0;
            bus.if_id_instr <= NOP_INS;
            bus.if_id_pc1   <= '0;
            bus.if_id_valid <= 1'b0;
            bus.ret_addr    <= '0;
            bus.ret_we      <= 1'b0;
            bus.int_ack     <= 1'b0;
        end else begin
            bus.ret_we  <= 1'b0;
            bus.int_ack <= 1'b0;
            unique case (state)
                BOOT: begin
                    pc              <= bus.next_pc;
                    bus.if_id_instr <= NOP_INS;
                    bus.if_id_valid <= 1'b0;
                end
                RUN: begin
                    if (bus.flush) begin
                        pc              <= bus.next_pc;
                        bus.if_id_instr <= NOP_INS;
                        bus.if_id_valid <= 1'b0;
                    end else if (bus.stall) begin
                        pc <= pc;
                    end else if (pending) begin
                        bus.ret_addr    <= pc;
                        bus.ret_we      <= 1'b1;
                        bus.if_id_instr <= NOP_INS;
                        bus.if_id_valid <= 1'b0;
                    end else begin
                        pc              <= bus.next_pc;
                        bus.if_id_instr <= bus.imem_data;
                        bus.if_id_pc1   <= bus.pc_plus1;
                        bus.if_id_valid <= 1'b1;
                    end
                end
                INT_SAVE: begin
                    pc              <= bus.next_pc;
                    bus.int_ack     <= 1'b1;
                    bus.if_id_instr <= NOP_INS;
                    bus.if_id_valid <= 1'b0;
                end
                INT_JUMP: begin
                    bus.if_id_instr <= NOP_INS;
                    bus.if_id_valid <= 1'b0;
                end
                default: begin
                    bus.if_id_instr <= NOP_INS;
                    bus.if_id_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed-vector bench for pc_fetch_stage: boot, fetch, stall/flush,
// interrupt entry and deferral, wrap and reset abort.
module tb_pc_fetch_stage;

    logic clk = 1'b0;
    logic rst;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    pc_fetch_stage_if #(.PC_W(8)) bus ();

    pc_fetch_stage #(.PC_W(8), .NOP_INS(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] npc, input logic [7:0] ins,
                         input logic st, input logic fl, input logic iq);
        bus.next_pc   = npc;
        bus.imem_data = ins;
        bus.stall     = st;
        bus.flush     = fl;
        bus.irq       = iq;
    endtask

    initial begin
        // 1. reset and boot
        rst = 1'b1;
        drive(8'h40, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        chk("rst_pc",       bus.imem_addr,   8'h00);
        chk("rst_instr",    bus.if_id_instr, 8'h00);
        chk("rst_pc1",      bus.if_id_pc1,   8'h00);
        chk("rst_valid",    bus.if_id_valid, 1'b0);
        chk("rst_ret",      bus.ret_addr,    8'h00);
        chk("rst_we",       bus.ret_we,      1'b0);
        chk("rst_ack",      bus.int_ack,     1'b0);
        chk("boot_fvec",    bus.force_vec,   1'b1);
        rst = 1'b0;
        drive(8'h40, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        chk("boot_pc",      bus.imem_addr,   8'h40);
        chk("boot_valid",   bus.if_id_valid, 1'b0);
        chk("run_fvec",     bus.force_vec,   1'b0);

        // 2. sequential fetch
        drive(8'h10, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        drive(8'h11, 8'hA5, 1'b0, 1'b0, 1'b0);
        tick();
        chk("seq_instr",    bus.if_id_instr, 8'hA5);
        chk("seq_pc1",      bus.if_id_pc1,   8'h11);
        chk("seq_pc",       bus.imem_addr,   8'h11);
        chk("seq_valid",    bus.if_id_valid, 1'b1);

        // 3. stall hold, then flush beats stall
        drive(8'h1F, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        drive(8'h20, 8'h3C, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(8'h99, 8'h77, 1'b1, 1'b0, 1'b0);
            tick();
            chk("stall_pc",    bus.imem_addr,   8'h20);
            chk("stall_instr", bus.if_id_instr, 8'h3C);
            chk("stall_pc1",   bus.if_id_pc1,   8'h20);
            chk("stall_valid", bus.if_id_valid, 1'b1);
        end
        drive(8'h80, 8'h77, 1'b1, 1'b1, 1'b0);
        tick();
        chk("sf_pc",        bus.imem_addr,   8'h80);
        chk("sf_valid",     bus.if_id_valid, 1'b0);
        chk("sf_instr",     bus.if_id_instr, 8'h00);

        // 4. interrupt at pc=33
        drive(8'h33, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        drive(8'h99, 8'h00, 1'b1, 1'b0, 1'b1);
        tick();
        chk("irq_hold_pc",  bus.imem_addr,   8'h33);
        chk("irq_hold_we",  bus.ret_we,      1'b0);
        drive(8'hF0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        chk("save_we",      bus.ret_we,      1'b1);
        chk("save_ret",     bus.ret_addr,    8'h33);
        chk("save_pc",      bus.imem_addr,   8'h33);
        chk("save_valid",   bus.if_id_valid, 1'b0);
        chk("save_ack",     bus.int_ack,     1'b0);
        chk("save_fvec",    bus.force_vec,   1'b0);
        tick();
        chk("jump_ack",     bus.int_ack,     1'b1);
        chk("jump_we",      bus.ret_we,      1'b0);
        chk("jump_pc",      bus.imem_addr,   8'hF0);
        chk("jump_valid",   bus.if_id_valid, 1'b0);
        chk("jump_fvec",    bus.force_vec,   1'b1);
        drive(8'h77, 8'h00, 1'b1, 1'b1, 1'b0);
        tick();
        chk("ret_ack",      bus.int_ack,     1'b0);
        chk("ret_pc",       bus.imem_addr,   8'hF0);
        chk("ret_valid",    bus.if_id_valid, 1'b0);
        drive(8'hF1, 8'h5A, 1'b0, 1'b0, 1'b0);
        tick();
        chk("vec_instr",    bus.if_id_instr, 8'h5A);
        chk("vec_pc1",      bus.if_id_pc1,   8'hF1);
        chk("vec_valid",    bus.if_id_valid, 1'b1);

        // 5. irq coincident with flush; irq during INT_JUMP
        drive(8'h50, 8'h00, 1'b0, 1'b1, 1'b1);
        tick();
        chk("def_pc",       bus.imem_addr,   8'h50);
        chk("def_we",       bus.ret_we,      1'b0);
        drive(8'hF0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        chk("def_we2",      bus.ret_we,      1'b1);
        chk("def_ret",      bus.ret_addr,    8'h50);
        tick();
        chk("def_ack",      bus.int_ack,     1'b1);
        drive(8'hF0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        chk("rearm_we",     bus.ret_we,      1'b0);
        drive(8'hF0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        chk("rearm_we2",    bus.ret_we,      1'b1);
        chk("rearm_ret",    bus.ret_addr,    8'hF0);
        tick();
        chk("rearm_ack",    bus.int_ack,     1'b1);
        tick();

        // 6. wrap, then reset aborting INT_SAVE
        drive(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        chk("wrap_pc",      bus.imem_addr,   8'hFF);
        chk("wrap_plus1",   bus.pc_plus1,    8'h00);
        drive(8'h00, 8'h11, 1'b0, 1'b0, 1'b0);
        tick();
        chk("wrap_pc1",     bus.if_id_pc1,   8'h00);
        chk("wrap_instr",   bus.if_id_instr, 8'h11);
        drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
        tick();
        drive(8'hF0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        chk("abort_we0",    bus.ret_we,      1'b1);
        rst = 1'b1;
        tick();
        chk("abort_we",     bus.ret_we,      1'b0);
        chk("abort_ack",    bus.int_ack,     1'b0);
        chk("abort_fvec",   bus.force_vec,   1'b1);
        chk("abort_pc",     bus.imem_addr,   8'h00);
        chk("abort_ret",    bus.ret_addr,    8'h00);
        rst = 1'b0;
        tick();
        chk("abort_ack2",   bus.int_ack,     1'b0);
        chk("abort_we2",    bus.ret_we,      1'b0);
        chk("abort_boot",   bus.imem_addr,   8'hF0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
